// File: rtl/gfx_irq_ctrl_if.sv
// AXI-Lite register-window interface (32-bit address and data) used by gfx_irq_ctrl.
// The s modport is the slave side and the m modport is the master side.
interface if_axil;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport s (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport m (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/gfx_irq_ctrl.sv
// GPU interrupt controller: pending/mask registers behind an AXI-Lite window with read-to-claim.
// Define GFX_IRQ_EDGE_EN to latch only on rising edges of src (level-sensitive by default).
module gfx_irq_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src,
  if_axil.s                axis,
  output logic             irq,
  output logic [4:0]       irq_id
);

  localparam logic [1:0]       REG_PENDING = 2'd0;
  localparam logic [1:0]       REG_MASK    = 2'd1;
  localparam logic [1:0]       REG_ACTIVE  = 2'd2;
  localparam logic [1:0]       REG_CLAIM   = 2'd3;
  localparam logic [N_SRC-1:0] SRC_ONE     = N_SRC'(1'b1);

  // Lowest set bit wins; 0 when nothing is set.
  function automatic logic [4:0] lowest_idx(input logic [N_SRC-1:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  logic [N_SRC-1:0] pending_r;
  logic [N_SRC-1:0] mask_r;
  logic             irq_r;
  logic [4:0]       irq_id_r;
  logic             aw_held_r;
  logic             w_held_r;
  logic [1:0]       aw_addr_r;
  logic [N_SRC-1:0] w_data_r;
  logic             bvalid_r;
  logic             rvalid_r;
  logic [31:0]      rdata_r;

  logic [N_SRC-1:0] active_s;
  logic [N_SRC-1:0] set_s;
  logic [N_SRC-1:0] w1c_s;
  logic [N_SRC-1:0] claim_clr_s;
  logic             mask_we_s;
  logic [31:0]      rdata_nxt_s;
  logic             aw_fire_s;
  logic             w_fire_s;
  logic             do_write_s;
  logic             b_fire_s;
  logic             ar_fire_s;
  logic             r_fire_s;
  logic [1:0]       wr_addr_s;
  logic [N_SRC-1:0] wr_data_s;
  logic             claim_valid_s;
  logic [4:0]       claim_id_s;
  logic             unused_s;

  assign active_s      = pending_r & mask_r;
  assign claim_valid_s = |active_s;
  assign claim_id_s    = lowest_idx(active_s);

  assign aw_fire_s  = axis.awvalid & ~aw_held_r;
  assign w_fire_s   = axis.wvalid & ~w_held_r;
  // The write lands on the edge where both halves are available, so B follows one cycle later.
  assign do_write_s = (aw_held_r | aw_fire_s) & (w_held_r | w_fire_s) & ~bvalid_r;
  assign b_fire_s   = bvalid_r & axis.bready;
  assign ar_fire_s  = axis.arvalid & ~rvalid_r;
  assign r_fire_s   = rvalid_r & axis.rready;
  assign wr_addr_s  = aw_held_r ? aw_addr_r : axis.awaddr[3:2];
  assign wr_data_s  = w_held_r ? w_data_r : axis.wdata[N_SRC-1:0];

  assign axis.awready = ~aw_held_r;
  assign axis.wready  = ~w_held_r;
  assign axis.bvalid  = bvalid_r;
  assign axis.bresp   = 2'b00;
  assign axis.arready = ~rvalid_r;
  assign axis.rvalid  = rvalid_r;
  assign axis.rdata   = rdata_r;
  assign axis.rresp   = 2'b00;
  assign irq          = irq_r;
  assign irq_id       = irq_id_r;

  assign unused_s = ^{axis.wstrb, axis.awaddr[31:4], axis.awaddr[1:0],
                      axis.araddr[31:4], axis.araddr[1:0], axis.wdata[31:N_SRC]};

`ifdef GFX_IRQ_EDGE_EN
  logic [N_SRC-1:0] src_q_r;

  // Previous-cycle copy of src for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q_r <= '0;
    end else begin
      src_q_r <= src;
    end
  end

  assign set_s = src & ~src_q_r;
`else
  assign set_s = src;
`endif

  // Write-side decode: W1C mask for PENDING and write enable for MASK.
  always_comb begin
    w1c_s     = '0;
    mask_we_s = 1'b0;
    if (do_write_s) begin
      case (wr_addr_s)
        REG_PENDING: w1c_s     = wr_data_s;
        REG_MASK:    mask_we_s = 1'b1;
        default: begin
          w1c_s     = '0;
          mask_we_s = 1'b0;
        end
      endcase
    end else begin
      w1c_s     = '0;
      mask_we_s = 1'b0;
    end
  end

  // Read mux and claim side effect; the claim sees the mask before any same-cycle write.
  always_comb begin
    rdata_nxt_s = 32'd0;
    claim_clr_s = '0;
    case (axis.araddr[3:2])
      REG_PENDING: rdata_nxt_s = 32'(pending_r);
      REG_MASK:    rdata_nxt_s = 32'(mask_r);
      REG_ACTIVE:  rdata_nxt_s = 32'(active_s);
      REG_CLAIM:   rdata_nxt_s = {claim_valid_s, 26'd0, claim_id_s};
      default:     rdata_nxt_s = 32'd0;
    endcase
    if (ar_fire_s && (axis.araddr[3:2] == REG_CLAIM) && claim_valid_s) begin
      claim_clr_s = SRC_ONE << claim_id_s;
    end else begin
      claim_clr_s = '0;
    end
  end

  // Pending and mask state plus the registered interrupt outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= '0;
      mask_r    <= '0;
      irq_r     <= 1'b0;
      irq_id_r  <= 5'd0;
    end else begin
      pending_r <= (pending_r & ~w1c_s & ~claim_clr_s) | set_s;
      if (mask_we_s) begin
        mask_r <= wr_data_s;
      end
      irq_r    <= claim_valid_s;
      irq_id_r <= claim_id_s;
    end
  end

  // Write channel: AW and W are held independently until the B beat completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      aw_addr_r <= 2'd0;
      w_data_r  <= '0;
      bvalid_r  <= 1'b0;
    end else begin
      if (b_fire_s) begin
        aw_held_r <= 1'b0;
      end else if (aw_fire_s) begin
        aw_held_r <= 1'b1;
        aw_addr_r <= axis.awaddr[3:2];
      end
      if (b_fire_s) begin
        w_held_r <= 1'b0;
      end else if (w_fire_s) begin
        w_held_r <= 1'b1;
        w_data_r <= axis.wdata[N_SRC-1:0];
      end
      if (do_write_s) begin
        bvalid_r <= 1'b1;
      end else if (b_fire_s) begin
        bvalid_r <= 1'b0;
      end
    end
  end

  // Read channel: data is captured on AR and held until the R handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_r <= 1'b0;
      rdata_r  <= 32'd0;
    end else begin
      if (ar_fire_s) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rdata_nxt_s;
      end else if (r_fire_s) begin
        rvalid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gfx_irq_ctrl.sv
// Scoreboard testbench for gfx_irq_ctrl: reads/writes push expected beats, a monitor pops them.
module tb_gfx_irq_ctrl;
  localparam int N = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] src   = '0;
  logic         irq;
  logic [4:0]   irq_id;

  if_axil axi();

  gfx_irq_ctrl #(.N_SRC(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .src    (src),
    .axis   (axi),
    .irq    (irq),
    .irq_id (irq_id)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] rd_q[$];
  logic [1:0]  b_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // Monitor: every R or B beat accepted by the master is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && axi.rvalid && axi.rready) begin
      if (rd_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_unexpected: got %h expected no beat", axi.rdata);
      end else begin
        chk("rdata", axi.rdata, rd_q.pop_front());
        chk("rresp", 32'(axi.rresp), 32'd0);
      end
    end
    if (rst_n && axi.bvalid && axi.bready) begin
      if (b_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL b_unexpected: got %h expected no beat", axi.bresp);
      end else begin
        chk("bresp", 32'(axi.bresp), 32'(b_q.pop_front()));
      end
    end
  end

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    int n;
    @(posedge clk); #1;
    axi.araddr  = addr;
    axi.arvalid = 1'b1;
    axi.rready  = 1'b1;
    rd_q.push_back(exp);
    n = 0;
    while (!axi.arready && n < 50) begin @(posedge clk); #1; n++; end
    if (!axi.arready) timeout("ar_wait");
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    n = 0;
    while (!axi.rvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!axi.rvalid) timeout("r_wait");
    @(posedge clk); #1;
  endtask

  // pulse bits are raised on src for exactly the cycle in which the write is accepted.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [N-1:0] pulse);
    int n;
    @(posedge clk); #1;
    axi.awaddr  = addr;
    axi.awvalid = 1'b1;
    axi.wdata   = data;
    axi.wstrb   = 4'hF;
    axi.wvalid  = 1'b1;
    src         = src | pulse;
    n = 0;
    while (!(axi.awready && axi.wready) && n < 50) begin @(posedge clk); #1; n++; end
    if (!(axi.awready && axi.wready)) timeout("aw_w_wait");
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    src         = src & ~pulse;
    b_q.push_back(2'b00);
    n = 0;
    while (!axi.bvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!axi.bvalid) timeout("b_wait");
    @(posedge clk); #1;
  endtask

  task automatic pulse_src(input logic [N-1:0] v);
    @(posedge clk); #1;
    src = v;
    @(posedge clk); #1;
    src = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    axi.awaddr = 32'd0; axi.awvalid = 1'b0; axi.wdata = 32'd0; axi.wstrb = 4'h0;
    axi.wvalid = 1'b0;  axi.bready = 1'b1;  axi.araddr = 32'd0; axi.arvalid = 1'b0;
    axi.rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_irq_id", 32'(irq_id), 32'd0);
    chk("rst_rvalid", 32'(axi.rvalid), 32'd0);
    chk("rst_bvalid", 32'(axi.bvalid), 32'd0);
    chk("rst_rdata", axi.rdata, 32'd0);
    chk("rst_readies", {29'd0, axi.awready, axi.wready, axi.arready}, 32'h7);
    rst_n = 1'b1;

    // Idle register map
    rd(32'h0, 32'h0);
    rd(32'h4, 32'h0);
    rd(32'h8, 32'h0);
    rd(32'hC, 32'h0);
    chk("idle_irq", 32'(irq), 32'd0);

    // Masked request
    pulse_src(8'h08);
    rd(32'h0, 32'h08);
    rd(32'h8, 32'h00);
    chk("masked_irq", 32'(irq), 32'd0);
    wr(32'h4, 32'h08, 8'h00);
    chk("unmask_irq", 32'(irq), 32'd1);
    chk("unmask_id", 32'(irq_id), 32'd3);
    rd(32'h8, 32'h08);

    // Priority and claim
    wr(32'h0, 32'h08, 8'h00);
    wr(32'h4, 32'hFF, 8'h00);
    chk("cleared_irq", 32'(irq), 32'd0);
    pulse_src(8'h24);
    @(posedge clk); #1;
    chk("prio_irq", 32'(irq), 32'd1);
    chk("prio_id", 32'(irq_id), 32'd2);
    rd(32'hC, 32'h8000_0002);
    chk("after_claim1_id", 32'(irq_id), 32'd5);
    rd(32'hC, 32'h8000_0005);
    chk("after_claim2_irq", 32'(irq), 32'd0);
    rd(32'hC, 32'h0000_0000);

    // W1C collides with a set on the same bit: set wins
    wr(32'h0, 32'h01, 8'h01);
    rd(32'h0, 32'h01);
    wr(32'h0, 32'h01, 8'h00);
    rd(32'h0, 32'h00);

    // Level vs edge with src[1] held high
    @(posedge clk); #1;
    src = 8'h02;
    repeat (2) @(posedge clk);
    wr(32'h0, 32'h02, 8'h00);
`ifdef GFX_IRQ_EDGE_EN
    rd(32'h0, 32'h00);
`else
    rd(32'h0, 32'h02);
`endif
    src = 8'h00;
    wr(32'h0, 32'h02, 8'h00);
    rd(32'h0, 32'h00);

    // W presented three cycles before AW
    @(posedge clk); #1;
    axi.awaddr = 32'h4;
    axi.wdata  = 32'h0F;
    axi.wvalid = 1'b1;
    @(posedge clk); #1;
    axi.wvalid = 1'b0;
    chk("w_held_wready", 32'(axi.wready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("w_only_bvalid", 32'(axi.bvalid), 32'd0);
    axi.awvalid = 1'b1;
    b_q.push_back(2'b00);
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
    chk("b_latency", 32'(axi.bvalid), 32'd1);
    @(posedge clk); #1;
    chk("post_b_awready", 32'(axi.awready), 32'd1);
    rd(32'h4, 32'h0F);

    // rready held low: rdata stays put while pending changes underneath
    @(posedge clk); #1;
    axi.araddr  = 32'h0;
    axi.arvalid = 1'b1;
    axi.rready  = 1'b0;
    rd_q.push_back(32'h0);
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    src = 8'h10;
    chk("hold_rvalid", 32'(axi.rvalid), 32'd1);
    @(posedge clk); #1;
    src = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rdata", axi.rdata, 32'h0);
    end
    @(posedge clk); #1;
    axi.rready = 1'b1;
    @(posedge clk); #1;
    rd(32'h0, 32'h10);

    // Reset in the middle of a read
    @(posedge clk); #1;
    axi.araddr  = 32'h0;
    axi.arvalid = 1'b1;
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    chk("midrd_rvalid", 32'(axi.rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rvalid", 32'(axi.rvalid), 32'd0);
    chk("rst_mid_rdata", axi.rdata, 32'd0);
    chk("rst_mid_arready", 32'(axi.arready), 32'd1);
    rd_q.delete();
    @(posedge clk); #1;
    rst_n      = 1'b1;
    axi.rready = 1'b1;
    rd(32'h0, 32'h0);
    rd(32'h4, 32'h0);

    repeat (2) @(posedge clk);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    chk("b_q_drained", 32'(b_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
